// File: rtl/stage_if.sv
// Stage/write bus between the stage sequencer and its environment: the decoder, register file, ALU and data memory.
// master: environment side. It drives instruction fields, regfile/ALU/memory data and mem_ready.
// slave : the sequencer. It drives stage code, regfile controls, operands, mem_req and status.
interface stage_if;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 7;

    logic              start;
    logic [OP_W-1:0]   opcode;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rf_out;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic [2:0]        sup;
    logic [REG_W-1:0]  rf_address;
    logic              rf_write;
    logic              rf_control;
    logic              rf_mem_to_reg;
    logic [DATA_W-1:0] rf_in;
    logic [DATA_W-1:0] rf_in_m;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              mem_req;
    logic              busy;
    logic              done;
    logic              illegal;

    modport master (
        output start, opcode, rs1, rs2, rd, rf_out, alu_result, mem_data, mem_ready,
        input  sup, rf_address, rf_write, rf_control, rf_mem_to_reg, rf_in, rf_in_m,
               op_a, op_b, mem_req, busy, done, illegal
    );

    modport slave (
        input  start, opcode, rs1, rs2, rd, rf_out, alu_result, mem_data, mem_ready,
        output sup, rf_address, rf_write, rf_control, rf_mem_to_reg, rf_in, rf_in_m,
               op_a, op_b, mem_req, busy, done, illegal
    );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: READ rs1, READ rs2, EX, MEM, WB.
// It captures operands from the registered regfile read port and holds memory requests until completion.
// It drives a single writeback stage.
// Ports: clk, rst (async active-high), bus (stage_if.slave).
// Optional macro STAGE_TIMEOUT_EN: aborts a load/store after MEM_TIMEOUT MEM cycles without mem_ready.
// The abort returns to IDLE with an illegal pulse and no writeback.
module stage_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic   clk,
    input  logic   rst,
    stage_if.slave bus
);
    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 7;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD1  = 3'd1;
    localparam logic [2:0] S_RD2  = 3'd2;
    localparam logic [2:0] S_EX   = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;

    localparam logic [2:0] SUP_IDLE = 3'b000;
    localparam logic [2:0] SUP_READ = 3'b001;
    localparam logic [2:0] SUP_EX   = 3'b010;
    localparam logic [2:0] SUP_MEM  = 3'b011;
    localparam logic [2:0] SUP_WB   = 3'b100;

    localparam logic [OP_W-1:0] OP_R     = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I     = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;

    if (MEM_TIMEOUT == 0) begin : g_bad_timeout
        $error("stage_sequencer: MEM_TIMEOUT must be at least 1");
    end

    logic [2:0]        state;
    logic [2:0]        state_n;
    logic [OP_W-1:0]   opcode_q;
    logic [REG_W-1:0]  rs2_q;
    logic [REG_W-1:0]  rd_q;

    logic [2:0]        sup_q,        sup_n;
    logic [REG_W-1:0]  rf_address_q, rf_address_n;
    logic              rf_write_q,   rf_write_n;
    logic              rf_control_q, rf_control_n;
    logic              m2r_q,        m2r_n;
    logic              mem_req_q,    mem_req_n;
    logic              busy_q,       busy_n;
    logic              done_q,       done_n;
    logic              illegal_q,    illegal_n;
    logic [DATA_W-1:0] op_a_q, op_b_q, rf_in_q, rf_in_m_q;

    logic start_legal_c;
    logic is_load_c;
    logic is_mem_c;
    logic is_alu_c;

    assign start_legal_c = bus.opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE};
    assign is_load_c     = (opcode_q == OP_LOAD);
    assign is_mem_c      = is_load_c || (opcode_q == OP_STORE);
    assign is_alu_c      = (opcode_q == OP_R) || (opcode_q == OP_I);

`ifdef STAGE_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts cycles spent in MEM; cleared whenever MEM is left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                tmo_cnt <= '0;
        else if (state == S_MEM) tmo_cnt <= tmo_cnt + TMO_W'(1);
        else                    tmo_cnt <= '0;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state plus next values of the state-decoded outputs.
    always_comb begin
        state_n      = state;
        illegal_n    = 1'b0;
        sup_n        = SUP_IDLE;
        rf_address_n = '0;
        rf_write_n   = 1'b0;
        rf_control_n = 1'b0;
        m2r_n        = 1'b0;
        mem_req_n    = 1'b0;
        done_n       = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (start_legal_c) state_n = S_RD1;
                    else               illegal_n = 1'b1;
                end
            end
            S_RD1: state_n = S_RD2;
            S_RD2: state_n = S_EX;
            S_EX:  state_n = S_MEM;
            S_MEM: begin
                if (!is_mem_c || bus.mem_ready) begin
                    state_n = S_WB;
                end
`ifdef STAGE_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1)) begin
                    state_n   = S_IDLE;
                    illegal_n = 1'b1;
                end
`endif
            end
            S_WB:    state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);

        case (state_n)
            S_RD1: begin
                // RD1 is entered only from IDLE on accept, so rs1 comes straight off the bus.
                sup_n        = SUP_READ;
                rf_address_n = bus.rs1;
            end
            S_RD2: begin
                sup_n        = SUP_READ;
                rf_address_n = rs2_q;
            end
            S_EX:  sup_n = SUP_EX;
            S_MEM: begin
                sup_n     = SUP_MEM;
                mem_req_n = is_mem_c;
            end
            S_WB: begin
                sup_n        = SUP_WB;
                rf_address_n = rd_q;
                rf_write_n   = 1'b1;
                done_n       = 1'b1;
                rf_control_n = (is_alu_c || is_load_c) && (rd_q != '0);
                m2r_n        = is_load_c;
            end
            default: sup_n = SUP_IDLE;
        endcase
    end

    // Output flops, instruction latch and datapath captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sup_q        <= SUP_IDLE;
            rf_address_q <= '0;
            rf_write_q   <= 1'b0;
            rf_control_q <= 1'b0;
            m2r_q        <= 1'b0;
            mem_req_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
            opcode_q     <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rf_in_q      <= '0;
            rf_in_m_q    <= '0;
        end else begin
            sup_q        <= sup_n;
            rf_address_q <= rf_address_n;
            rf_write_q   <= rf_write_n;
            rf_control_q <= rf_control_n;
            m2r_q        <= m2r_n;
            mem_req_q    <= mem_req_n;
            busy_q       <= busy_n;
            done_q       <= done_n;
            illegal_q    <= illegal_n;

            if (state == S_IDLE && bus.start && start_legal_c) begin
                opcode_q <= bus.opcode;
                rs2_q    <= bus.rs2;
                rd_q     <= bus.rd;
            end
            // Regfile read data lags its address by one cycle.
            if (state == S_RD2) op_a_q <= bus.rf_out;
            if (state == S_EX)  op_b_q <= bus.rf_out;
            if (state == S_MEM && !is_mem_c) rf_in_q <= bus.alu_result;
            if (state == S_MEM && is_load_c && bus.mem_ready) rf_in_m_q <= bus.mem_data;
        end
    end

    assign bus.sup           = sup_q;
    assign bus.rf_address    = rf_address_q;
    assign bus.rf_write      = rf_write_q;
    assign bus.rf_control    = rf_control_q;
    assign bus.rf_mem_to_reg = m2r_q;
    assign bus.mem_req       = mem_req_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.illegal       = illegal_q;
    assign bus.op_a          = op_a_q;
    assign bus.op_b          = op_b_q;
    assign bus.rf_in         = rf_in_q;
    assign bus.rf_in_m       = rf_in_m_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer. It provides an environment regfile and ALU, plus an instruction-level model.
// The model tracks the architectural register values and derives the stage trace from the opcode and memory wait.
module tb_stage_sequencer;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic clk = 1'b0;
    logic rst;
    logic seed_load;
    logic [63:0] regs [32];
    logic [63:0] seed [32];
    logic [63:0] gold [32];
    int total = 0;
    int bad   = 0;

    stage_if bus ();

    stage_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ALU environment: plain add of the captured operands.
    assign bus.alu_result = bus.op_a + bus.op_b;

    // Register file environment: registered read, write on WB with control set.
    always @(posedge clk) begin
        if (seed_load) begin
            for (int i = 0; i < 32; i++) regs[i] <= seed[i];
        end else if (bus.rf_write && bus.rf_control && bus.rf_address != 5'd0) begin
            regs[bus.rf_address] <= bus.rf_mem_to_reg ? bus.rf_in_m : bus.rf_in;
        end
        bus.rf_out <= regs[bus.rf_address];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [2:0] sup, input logic mreq, input logic ill);
        check($sformatf("%s.sup", tag),      64'(bus.sup),      64'(sup));
        check($sformatf("%s.busy", tag),     64'(bus.busy),     64'(sup != 3'b000));
        check($sformatf("%s.done", tag),     64'(bus.done),     64'(sup == 3'b100));
        check($sformatf("%s.rf_write", tag), 64'(bus.rf_write), 64'(sup == 3'b100));
        check($sformatf("%s.mem_req", tag),  64'(bus.mem_req),  64'(mreq));
        check($sformatf("%s.illegal", tag),  64'(bus.illegal),  64'(ill));
    endtask

    // While busy, optionally throw garbage on every input the sequencer must ignore.
    task automatic scramble(input bit noise);
        if (noise) begin
            bus.start     = 1'($urandom_range(1));
            bus.opcode    = 7'($urandom);
            bus.rs1       = 5'($urandom);
            bus.rs2       = 5'($urandom);
            bus.rd        = 5'($urandom);
            bus.mem_ready = 1'($urandom_range(1));
            bus.mem_data  = {$urandom, $urandom};
        end else begin
            bus.start     = 1'b0;
            bus.mem_ready = 1'b0;
        end
    endtask

    // One full instruction; k = MEM cycles until mem_ready for load/store, mdv = data returned.
    task automatic run_instr(input logic [6:0] opc, input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] d, input int k, input logic [63:0] mdv, input bit noise);
        bit ld, mem, alu, wr;
        logic [63:0] ea, eb, res;
        ld  = (opc == OP_LD);
        mem = ld || (opc == OP_ST);
        alu = (opc == OP_R) || (opc == OP_I);
        wr  = (alu || ld) && (d != 5'd0);
        ea  = gold[a];
        eb  = gold[b];
        res = ea + eb;

        bus.start = 1'b1; bus.opcode = opc; bus.rs1 = a; bus.rs2 = b; bus.rd = d;
        bus.mem_ready = noise ? 1'($urandom_range(1)) : 1'b0;
        tick();
        scramble(noise);
        chk_ctl("rd1", 3'b001, 1'b0, 1'b0);
        check("rd1.addr", 64'(bus.rf_address), 64'(a));
        check("rd1.ctrl", 64'(bus.rf_control), 64'(1'b0));
        tick();
        scramble(noise);
        chk_ctl("rd2", 3'b001, 1'b0, 1'b0);
        check("rd2.addr", 64'(bus.rf_address), 64'(b));
        tick();
        scramble(noise);
        chk_ctl("ex", 3'b010, 1'b0, 1'b0);
        check("ex.op_a", bus.op_a, ea);
        tick();
        chk_ctl("mem", 3'b011, 1'(mem), 1'b0);
        check("mem.op_b", bus.op_b, eb);
        if (mem) begin
            for (int j = 1; j <= k; j++) begin
                if (j > 1) begin
                    tick();
                    chk_ctl("mem_wait", 3'b011, 1'b1, 1'b0);
                end
                scramble(noise);
                bus.mem_ready = (j == k);
                bus.mem_data  = (j == k) ? mdv : {$urandom, $urandom};
            end
        end else begin
            scramble(noise);
        end
        tick();
        scramble(noise);
        chk_ctl("wb", 3'b100, 1'b0, 1'b0);
        check("wb.addr", 64'(bus.rf_address), 64'(d));
        check("wb.ctrl", 64'(bus.rf_control), 64'(wr));
        check("wb.m2r",  64'(bus.rf_mem_to_reg), 64'(ld));
        if (alu) check("wb.rf_in", bus.rf_in, res);
        if (ld)  check("wb.rf_in_m", bus.rf_in_m, mdv);
        tick();
        bus.start = 1'b0;
        bus.mem_ready = 1'b0;
        chk_ctl("idle", 3'b000, 1'b0, 1'b0);
        if (wr) gold[d] = ld ? mdv : res;
    endtask

    task automatic run_illegal();
        bus.start = 1'b1; bus.opcode = OP_BAD;
        bus.rs1 = 5'($urandom); bus.rs2 = 5'($urandom); bus.rd = 5'($urandom);
        tick();
        bus.start = 1'b0;
        chk_ctl("illegal", 3'b000, 1'b0, 1'b1);
        check("illegal.addr", 64'(bus.rf_address), 64'(0));
        tick();
        chk_ctl("illegal_after", 3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        int r;
        rst = 1'b1;
        seed_load = 1'b1;
        bus.start = 1'b0; bus.opcode = '0; bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0;
        bus.mem_data = '0; bus.mem_ready = 1'b0;
        for (int i = 0; i < 32; i++) seed[i] = (i == 0) ? 64'd0 : {$urandom, $urandom};
        seed[3] = 64'd10;
        seed[4] = 64'd7;
        gold = seed;
        repeat (2) @(posedge clk);
        #1;

        chk_ctl("reset", 3'b000, 1'b0, 1'b0);
        check("reset.addr", 64'(bus.rf_address), 64'(0));
        check("reset.ctrl", 64'(bus.rf_control), 64'(1'b0));
        check("reset.m2r",  64'(bus.rf_mem_to_reg), 64'(1'b0));
        check("reset.op_a", bus.op_a, 64'd0);
        check("reset.op_b", bus.op_b, 64'd0);
        check("reset.rf_in", bus.rf_in, 64'd0);
        check("reset.rf_in_m", bus.rf_in_m, 64'd0);
        seed_load = 1'b0;
        rst = 1'b0;
        tick();
        chk_ctl("idle0", 3'b000, 1'b0, 1'b0);

        // R-type 10 + 7 into x5.
        run_instr(OP_R, 5'd3, 5'd4, 5'd5, 1, 64'd0, 1'b0);
        check("rtype.x5", gold[5], 64'd17);
        // Load after 3 MEM cycles.
        run_instr(OP_LD, 5'd1, 5'd2, 5'd6, 3, 64'hDEAD, 1'b0);
        // Store: no register update.
        run_instr(OP_ST, 5'd5, 5'd6, 5'd7, 2, 64'd0, 1'b0);
        // rd = 0 with busy-time start noise.
        run_instr(OP_R, 5'd5, 5'd6, 5'd0, 1, 64'd0, 1'b1);

        // Async reset during EX.
        bus.start = 1'b1; bus.opcode = OP_R; bus.rs1 = 5'd5; bus.rs2 = 5'd6; bus.rd = 5'd9;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk_ctl("pre_rst", 3'b010, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_ctl("rst_async", 3'b000, 1'b0, 1'b0);
        check("rst_async.op_a", bus.op_a, 64'd0);
        #2;
        rst = 1'b0;
        tick();
        chk_ctl("post_rst", 3'b000, 1'b0, 1'b0);
        run_instr(OP_I, 5'd6, 5'd5, 5'd9, 1, 64'd0, 1'b0);

        run_illegal();

`ifdef STAGE_TIMEOUT_EN
        // Load that never completes.
        bus.start = 1'b1; bus.opcode = OP_LD; bus.rs1 = 5'd1; bus.rs2 = 5'd2; bus.rd = 5'd8;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        for (int j = 1; j <= 15; j++) begin
            chk_ctl("tmo_mem", 3'b011, 1'b1, 1'b0);
            tick();
        end
        chk_ctl("tmo_abort", 3'b000, 1'b0, 1'b1);
        tick();
        chk_ctl("tmo_after", 3'b000, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(9));
            if (r == 9) begin
                run_illegal();
            end else begin
                run_instr((r < 3) ? OP_R : (r < 5) ? OP_I : (r < 7) ? OP_LD : OP_ST,
                          5'($urandom), 5'($urandom), 5'($urandom),
                          int'($urandom_range(5, 1)), {$urandom, $urandom},
                          1'($urandom_range(1)));
            end
        end

        for (int i = 0; i < 32; i++) check($sformatf("regfile[%0d]", i), regs[i], gold[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
